rng_bit_conditioner: RTL and testbench

Entropy-front-end stage that samples a raw noise bit, optionally removes bias with a von Neumann extractor, buffers the conditioned bits in a small FIFO and frames them into fixed-length sequences. It sits directly upstream of the approximate-entropy test core and supplies its serial epsilon bit stream. It also counts FIFO overflow drops so the host can detect an under-read stream.

---
 rtl/rng_bit_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_rng_bit_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_bit_conditioner.sv
// rng_bit_conditioner
//
// Entropy front end. It resynchronises a raw noise bit and samples it on
// raw_strobe. It can optionally debias the samples with a von Neumann
// extractor. The conditioned bits are buffered in a small bit FIFO, and the
// FIFO output is framed into SEQ_LEN-bit sequences for the downstream
// approximate-entropy test core.
//
// Optional feature macro: RNG_COND_LFSR_EN
//   When defined, adds the test_mode input and a 16-bit Fibonacci LFSR
//   (x^16+x^14+x^13+x^11+1, seed 16'hACE1) that can replace the
//   synchronised noise bit as the sample source.
//
// Parameters
//   FIFO_DEPTH  buffer depth in bits (power of two, >= 4)
//   SEQ_LEN     bits per framed sequence (2..65535)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   raw_bit     asynchronous raw noise bit
//   raw_strobe  one sample per high cycle
//   debias_en   1 = von Neumann extraction, 0 = pass-through
//   test_mode   (RNG_COND_LFSR_EN only) sample the LFSR instead of raw_bit
//   out_bit     conditioned bit at the FIFO head
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_bit
//   out_last    final bit of a SEQ_LEN-bit sequence
//   drop_cnt    saturating count of bits dropped on a full FIFO

module rng_bit_conditioner #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SEQ_LEN    = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_bit,
    input  logic       raw_strobe,
    input  logic       debias_en,
`ifdef RNG_COND_LFSR_EN
    input  logic       test_mode,
`endif
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] drop_cnt
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_FULL = FIFO_DEPTH[AW:0];
    localparam logic [15:0] SEQ_LAST   = 16'(SEQ_LEN - 1);

    // Synchroniser and sample source
    logic sync1;
    logic sync2;
    logic sample_val;

    // Von Neumann pair tracking
    logic debias_q;
    logic pair_half;
    logic first_bit;
    logic pair_half_d;
    logic first_bit_d;
    logic mode_change;

    // Push request from the conditioner
    logic push;
    logic push_bit;

    // FIFO state
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW:0]           fill_cnt;
    logic                  full;
    logic                  pop;
    logic                  accept;
    logic                  drop;

    // Framing
    logic [15:0] seq_cnt;

`ifdef RNG_COND_LFSR_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign sample_val = test_mode ? lfsr[0] : sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (raw_strobe) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign sample_val = sync2;
`endif

    // Conditioner: decides whether this cycle's sample produces a push.
    // A mode change clears the pair state, and a sample in that same cycle
    // is treated as the first half of a fresh pair.
    always_comb begin
        push        = 1'b0;
        push_bit    = sample_val;
        mode_change = (debias_en != debias_q);
        pair_half_d = mode_change ? 1'b0 : pair_half;
        first_bit_d = mode_change ? 1'b0 : first_bit;

        if (raw_strobe) begin
            if (!debias_en) begin
                push = 1'b1;
            end else if (!pair_half_d) begin
                pair_half_d = 1'b1;
                first_bit_d = sample_val;
            end else begin
                pair_half_d = 1'b0;
                if (sample_val != first_bit_d) begin
                    push     = 1'b1;
                    push_bit = first_bit_d;
                end
            end
        end
    end

    // FIFO control: a push into a full FIFO is still accepted when the head
    // leaves in the same cycle.
    assign out_valid = (fill_cnt != '0);
    assign out_bit   = mem[rd_ptr];
    assign out_last  = out_valid && (seq_cnt == SEQ_LAST);
    assign full      = (fill_cnt == DEPTH_FULL);
    assign pop       = out_valid && out_ready;
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            debias_q  <= 1'b0;
            pair_half <= 1'b0;
            first_bit <= 1'b0;
            mem       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            drop_cnt  <= '0;
            seq_cnt   <= '0;
        end else begin
            sync1     <= raw_bit;
            sync2     <= sync1;
            debias_q  <= debias_en;
            pair_half <= pair_half_d;
            first_bit <= first_bit_d;

            if (accept) begin
                mem[wr_ptr] <= push_bit;
                wr_ptr      <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                seq_cnt <= out_last ? '0 : seq_cnt + 16'd1;
            end

            if (accept && !pop) begin
                fill_cnt <= fill_cnt + 1'b1;
            end else if (pop && !accept) begin
                fill_cnt <= fill_cnt - 1'b1;
            end

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rng_bit_conditioner.sv
// Testbench for rng_bit_conditioner (FIFO_DEPTH=16, SEQ_LEN=4).
// Expected bits are queued when stimulus is issued; a monitor pops and
// compares on every accepted output bit and checks out_last against its own
// sequence position counter.

module tb_rng_bit_conditioner;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SEQ   = 4;

    logic       clk;
    logic       rst;
    logic       raw_bit;
    logic       raw_strobe;
    logic       debias_en;
`ifdef RNG_COND_LFSR_EN
    logic       test_mode;
`endif
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] drop_cnt;

    rng_bit_conditioner #(
        .FIFO_DEPTH (DEPTH),
        .SEQ_LEN    (SEQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_bit    (raw_bit),
        .raw_strobe (raw_strobe),
        .debias_en  (debias_en),
`ifdef RNG_COND_LFSR_EN
        .test_mode  (test_mode),
`endif
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic exp_q[$];

    int   model_seq = 0;
    int   last_seen = 0;
    bit   track_valid = 1'b0;
    int   first_valid_cyc = -1;
    int   drive_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            model_seq = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got bit %0d expected no output", out_bit);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk("out_bit", {31'd0, out_bit}, {31'd0, e});
                chk("out_last", {31'd0, out_last}, (model_seq == SEQ - 1) ? 32'd1 : 32'd0);
                if (out_last) last_seen++;
                model_seq = (model_seq == SEQ - 1) ? 0 : model_seq + 1;
            end
        end
        if (track_valid && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    task automatic push_exp(input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
    endtask

    // Drives bits[i] on raw_bit in cycle i and strobes from cycle 2 onward, so
    // strobe k samples bits[k] after the two-flop synchroniser.
    task automatic stream(input int n, input logic [31:0] bits);
        for (int i = 0; i < n + 2; i++) begin
            @(posedge clk); #1;
            raw_bit    = (i < n) ? bits[i] : 1'b0;
            raw_strobe = (i >= 2);
            if (i == 0) drive_cyc = cyc;
        end
        @(posedge clk); #1;
        raw_strobe = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_drain: got %0d bits left expected 0", name, exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        raw_bit    = 1'b1;
        raw_strobe = 1'b1;
        debias_en  = 1'b0;
        out_ready  = 1'b1;
`ifdef RNG_COND_LFSR_EN
        test_mode  = 1'b0;
`endif

        // Reset held 3 cycles with strobes active: outputs stay quiet.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {21'd0, out_valid, out_bit, out_last, drop_cnt}, 32'd0);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        raw_strobe = 1'b0;
        @(negedge clk);
        chk("post_reset_drop", {24'd0, drop_cnt}, 32'd0);
        chk("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // Pass-through 1,0,1,1; first valid 3 cycles after first drive.
        push_exp(4, 32'b1101);
        track_valid = 1'b1;
        first_valid_cyc = -1;
        stream(4, 32'b1101);
        drain("pass");
        track_valid = 1'b0;
        chk("pass_latency", first_valid_cyc - drive_cyc, 32'd3);

        // Von Neumann: pairs 10,11,01,00,10 -> 1,0,1.
        debias_en = 1'b1;
        push_exp(3, 32'b101);
        stream(10, 32'b0100101101);
        drain("vn");

        // Mode toggle after a first half abandons it; next pair 01 -> 0.
        push_exp(1, 32'b0);
        stream(1, 32'b1);
        @(posedge clk); #1; debias_en = 1'b0;
        @(posedge clk); #1; debias_en = 1'b1;
        stream(2, 32'b10);
        drain("vn_toggle");

        // Overflow: 20 strobes into a blocked 16-deep FIFO.
        debias_en = 1'b0;
        out_ready = 1'b0;
        push_exp(16, 32'h000A5C3F);
        stream(20, 32'h000A5C3F);
        @(negedge clk);
        chk("ovf_fill", {27'd0, dut.fill_cnt}, 32'd16);
        chk("ovf_drop", {24'd0, drop_cnt}, 32'd4);
        out_ready = 1'b1;
        push_exp(8, 32'h96);
        stream(8, 32'h96);
        drain("ovf");
        chk("ovf_drop_after", {24'd0, drop_cnt}, 32'd4);

        // Drop counter saturation.
        out_ready = 1'b0;
        raw_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(16, 32'd0);
        raw_strobe = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        raw_strobe = 1'b0;
        @(negedge clk);
        chk("sat_fill", {27'd0, dut.fill_cnt}, 32'd16);
        chk("sat_drop", {24'd0, drop_cnt}, 32'd255);

        // Reset mid-operation discards everything.
        pulse_reset();
        @(negedge clk);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("midrst_fill", {27'd0, dut.fill_cnt}, 32'd0);

        // Framing: 10 bits, SEQ_LEN=4 -> last on pops 4 and 8, seq_cnt ends at 2.
        out_ready = 1'b1;
        last_seen = 0;
        push_exp(10, 32'h2B5);
        stream(10, 32'h2B5);
        drain("frame");
        chk("frame_seq_cnt", {16'd0, dut.seq_cnt}, 32'd2);
        chk("frame_last_count", last_seen, 32'd2);

`ifdef RNG_COND_LFSR_EN
        // LFSR source: first 16 outputs are the seed bits, LSB first.
        pulse_reset();
        test_mode = 1'b1;
        push_exp(16, 32'h0000ACE1);
        stream(16, 32'd0);
        drain("lfsr");
        test_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
